// File: rtl/seqplu_checker_if.sv
// Phase-bus bundle between a four-phase pulse generator and its checker.
//   en       : sample strobe (generator side drives)
//   q_in     : one-hot phase bus, WIDTH bits
//   err_clr  : synchronous clear of the error counter
//   phase    : decoded phase index (checker drives)
//   phase_vld: pulse, phase updated from a legal sample
//   locked   : level, rotation tracked and correct
//   err      : pulse, sequence error while locked
//   err_cnt  : saturating error count, ERR_W bits
interface seqplu_checker_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  localparam int PW = $clog2(WIDTH);

  logic             en;
  logic [WIDTH-1:0] q_in;
  logic             err_clr;
  logic [PW-1:0]    phase;
  logic             phase_vld;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output en, q_in, err_clr,
    input  phase, phase_vld, locked, err, err_cnt
  );

  modport slave (
    input  en, q_in, err_clr,
    output phase, phase_vld, locked, err, err_cnt
  );
endinterface

// File: rtl/seqplu_checker.sv
// Receive-side checker for a one-hot rotating phase bus.
// Decodes the active phase each enabled cycle, verifies the rotation
// MSB -> ... -> LSB -> MSB, declares lock after LOCK_CNT correct steps and
// flags/counts sequence errors once locked.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : seqplu_checker_if slave (en, q_in, err_clr in; phase, phase_vld,
//          locked, err, err_cnt out). All outputs registered.
module seqplu_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  seqplu_checker_if.slave       bus
);
  localparam int PW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    HUNT,
    TRACK,
    LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    exp_q, exp_d;
  logic [7:0]       good_cnt_q, good_cnt_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             phase_vld_q, phase_vld_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             legal;
  logic [PW-1:0]    idx;
  logic [PW-1:0]    idx_nxt;
  logic [7:0]       good_inc;

  // Bit WIDTH-1 is phase 0, bit 0 is phase WIDTH-1.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (bus.q_in[i]) idx = PW'(WIDTH - 1 - i);
    end
    legal    = ($countones(bus.q_in) == 1);
    idx_nxt  = (idx == PW'(WIDTH - 1)) ? '0 : idx + 1'b1;
    good_inc = good_cnt_q + 8'd1;
  end

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    good_cnt_d  = good_cnt_q;
    phase_d     = phase_q;
    phase_vld_d = 1'b0;
    locked_d    = locked_q;
    err_d       = 1'b0;

    if (bus.en) begin
      if (legal) begin
        phase_d     = idx;
        phase_vld_d = 1'b1;
      end

      unique case (state_q)
        HUNT: begin
          if (legal) begin
            exp_d      = idx_nxt;
            good_cnt_d = 8'd1;
            state_d    = TRACK;
          end
        end
        TRACK: begin
          if (!legal) begin
            good_cnt_d = '0;
            state_d    = HUNT;
          end else if (idx == exp_q) begin
            good_cnt_d = good_inc;
            exp_d      = idx_nxt;
            if (good_inc == 8'(LOCK_CNT)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            // Mismatch restarts the run with this sample as its first step.
            good_cnt_d = 8'd1;
            exp_d      = idx_nxt;
          end
        end
        LOCKED: begin
          if (legal && (idx == exp_q)) begin
            exp_d = idx_nxt;
          end else begin
            // Offending sample is discarded, not used to reseed HUNT.
            err_d      = 1'b1;
            locked_d   = 1'b0;
            good_cnt_d = '0;
            state_d    = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // Clear wins over a simultaneous error event.
    err_cnt_d = err_cnt_q;
    if (bus.err_clr) begin
      err_cnt_d = '0;
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      exp_q       <= '0;
      good_cnt_q  <= '0;
      phase_q     <= '0;
      phase_vld_q <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      good_cnt_q  <= good_cnt_d;
      phase_q     <= phase_d;
      phase_vld_q <= phase_vld_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.phase     = phase_q;
  assign bus.phase_vld = phase_vld_q;
  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_seqplu_checker.sv
// Self-checking bench for seqplu_checker: directed scenarios followed by
// randomized traffic, compared each cycle against a run-length reference
// model. Two instances share stimulus; the second has a 2-bit error counter.
module tb_seqplu_checker;
  localparam int W    = 4;
  localparam int LOCK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [W-1:0] q = '0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  seqplu_checker_if #(.WIDTH(W), .ERR_W(8)) ia ();
  seqplu_checker_if #(.WIDTH(W), .ERR_W(2)) ib ();

  assign ia.en = en;  assign ia.q_in = q;  assign ia.err_clr = clr;
  assign ib.en = en;  assign ib.q_in = q;  assign ib.err_clr = clr;

  seqplu_checker #(.WIDTH(W), .LOCK_CNT(LOCK), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(ia.slave)
  );
  seqplu_checker #(.WIDTH(W), .LOCK_CNT(LOCK), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ib.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: length of the current run of correctly rotating
  // legal samples and the last legal index in that run.
  int m_run, m_prev, m_phase, m_cnt8, m_cnt2;
  bit m_locked, m_vld, m_err;

  task automatic chk(input string tag, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d want %0d", tag, $time, act, expv);
    end
  endtask

  function automatic logic [W-1:0] oh(input int i);
    logic [W-1:0] v;
    v = '0;
    v[W-1-i] = 1'b1;
    return v;
  endfunction

  task automatic model(input bit e, input logic [W-1:0] qq, input bit c, input bit r);
    bit lg;
    int ix;
    if (r) begin
      m_run = 0; m_prev = 0; m_phase = 0; m_cnt8 = 0; m_cnt2 = 0;
      m_locked = 0; m_vld = 0; m_err = 0;
      return;
    end
    m_vld = 0;
    m_err = 0;
    if (e) begin
      lg = ($countones(qq) == 1);
      ix = lg ? (W - 1 - $clog2(qq)) : 0;
      if (lg) begin
        m_phase = ix;
        m_vld   = 1;
      end
      if (m_locked) begin
        if (lg && ix == (m_prev + 1) % W) m_prev = ix;
        else begin
          m_err = 1; m_locked = 0; m_run = 0;
        end
      end else if (!lg) begin
        m_run = 0;
      end else begin
        if (m_run > 0 && ix == (m_prev + 1) % W) m_run++;
        else m_run = 1;
        m_prev = ix;
        if (m_run == LOCK) m_locked = 1;
      end
    end
    if (c) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (m_err) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic step(input bit e, input logic [W-1:0] qq, input bit c = 0, input bit r = 0);
    en = e; q = qq; clr = c; rst = r;
    @(posedge clk);
    #1;
    model(e, qq, c, r);
    chk("phase",     int'(ia.phase),     m_phase);
    chk("phase_vld", int'(ia.phase_vld), int'(m_vld));
    chk("locked",    int'(ia.locked),    int'(m_locked));
    chk("err",       int'(ia.err),       int'(m_err));
    chk("err_cnt",   int'(ia.err_cnt),   m_cnt8);
    chk("err_cnt2",  int'(ib.err_cnt),   m_cnt2);
    chk("locked_b",  int'(ib.locked),    int'(m_locked));
    rst = 0;
  endtask

  task automatic lock_from(input int s);
    for (int k = 0; k < LOCK; k++) step(1, oh((s + k) % W));
  endtask

  initial begin
    int gi;
    int sel;
    logic [W-1:0] rq;

    // Reset for two cycles.
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    chk("rst_locked", int'(ia.locked), 0);
    chk("rst_cnt", int'(ia.err_cnt), 0);

    // Lock acquisition.
    lock_from(0);
    chk("lock_acq", int'(ia.locked), 1);
    chk("lock_phase", int'(ia.phase), 3);

    // Wrap with an enable gap.
    step(1, oh(0));
    for (int k = 0; k < 3; k++) step(0, '0);
    chk("gap_phase", int'(ia.phase), 0);
    step(1, oh(1));
    chk("gap_locked", int'(ia.locked), 1);
    chk("gap_phase1", int'(ia.phase), 1);

    // Locked error: expect index 2, drive index 0.
    step(1, oh(0));
    chk("lerr_err", int'(ia.err), 1);
    chk("lerr_cnt", int'(ia.err_cnt), 1);
    step(1, oh(1));
    chk("lerr_pulse", int'(ia.err), 0);
    step(1, oh(2));
    step(1, oh(3));
    step(1, oh(0));
    chk("relock", int'(ia.locked), 1);

    // Illegal patterns while locked, then an illegal one in HUNT.
    step(1, 4'b0000);
    chk("ill0_vld", int'(ia.phase_vld), 0);
    chk("ill0_phase", int'(ia.phase), 0);
    lock_from(1);
    step(1, 4'b0110);
    chk("ill1_cnt", int'(ia.err_cnt), 3);
    step(1, 4'b1100);
    chk("hunt_noerr", int'(ia.err), 0);

    // Saturation of the 2-bit counter, then clear against an error.
    for (int k = 0; k < 5; k++) begin
      lock_from(k % W);
      step(1, 4'b0000);
    end
    chk("sat_cnt2", int'(ib.err_cnt), 3);
    chk("sat_cnt8", int'(ia.err_cnt), 8);
    lock_from(2);
    step(1, 4'b0000, 1);
    chk("clr_pri", int'(ia.err_cnt), 0);

    // TRACK restart, then lock on the restarted run.
    step(1, oh(0));
    step(1, oh(1));
    step(1, oh(3));
    chk("restart_nolock", int'(ia.locked), 0);
    step(1, oh(0));
    step(1, oh(1));
    step(1, oh(2));
    chk("restart_lock", int'(ia.locked), 1);

    // Reset mid-stream.
    step(1, oh(3), 0, 1);
    chk("mid_rst_locked", int'(ia.locked), 0);
    chk("mid_rst_vld", int'(ia.phase_vld), 0);

    // Randomized traffic biased towards the legal rotation.
    gi = 0;
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 75) begin
        gi = (gi + 1) % W;
        rq = oh(gi);
      end else if (sel < 88) begin
        gi = $urandom_range(0, W - 1);
        rq = oh(gi);
      end else begin
        rq = W'($urandom);
      end
      step(($urandom % 5) != 0, rq, ($urandom % 60) == 0, ($urandom % 400) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/seqplu_checker.md
Name: seqplu_checker

Overview:
- Receive-side counterpart of the four-phase sequential pulse generator. It samples a one-hot pulse bus each enabled cycle and decodes the active phase index.
- It checks that the bus steps through the legal rotation 1000 -> 0100 -> 0010 -> 0001 -> 1000, declares lock after a run of correct steps, and flags and counts sequence errors once locked.
- It sits at the consumer end of any one-hot phase bus driven by the generator.

Parameters:
- WIDTH, 4: number of phases and width of the one-hot bus. Minimum 2.
- LOCK_CNT, 4: consecutive correct legal samples needed to reach lock. Range 2..255.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  sample strobe; q_in is evaluated only when en=1.
- q_in  in  WIDTH  one-hot phase bus from the generator.
- err_clr  in  1  synchronous clear of err_cnt.
- phase  out  clog2(WIDTH)  decoded phase index, registered.
- phase_vld  out  1  one-cycle pulse: phase was updated from a legal sample.
- locked  out  1  level: sequence is tracked and correct.
- err  out  1  one-cycle pulse: sequence error while locked.
- err_cnt  out  ERR_W  saturating count of err pulses.

Behaviour:
- Reset (rst=1 at a clk edge): state=HUNT. phase=0, phase_vld=0, locked=0, err=0, err_cnt=0; internal exp=0, good_cnt=0. Reset mid-operation aborts any lock immediately.
- Legal sample: exactly one bit of q_in set. Bit WIDTH-1 set gives index 0; bit 0 set gives index WIDTH-1. For WIDTH=4: 1000->0, 0100->1, 0010->2, 0001->3.
- Illegal sample: zero bits set or more than one bit set.
- Latency: every output reflects the sample taken one clk edge earlier. All outputs are registered.
- en=0: state, exp, good_cnt, phase and locked hold; phase_vld=0; err=0.
- On any legal sample with en=1: phase <= index; phase_vld <= 1.
- On an illegal sample: phase holds; phase_vld <= 0.
- exp is the expected next index. It advances as index+1 modulo WIDTH, so WIDTH-1 wraps to 0.
- State HUNT:
  - Legal sample: exp <= index+1 mod WIDTH; good_cnt <= 1; go to TRACK.
  - Illegal sample: stay in HUNT.
  - No err is raised in HUNT.
- State TRACK:
  - Legal sample with index==exp: good_cnt increments and exp advances. If the new good_cnt==LOCK_CNT, go to LOCKED and set locked <= 1.
  - Legal sample with index!=exp: restart from this sample (good_cnt <= 1, exp <= index+1); stay in TRACK.
  - Illegal sample: go to HUNT with good_cnt <= 0.
  - No err is raised in TRACK.
- State LOCKED:
  - Legal sample with index==exp: exp advances; stay in LOCKED.
  - Mismatch or illegal sample: err <= 1 for one cycle; locked <= 0; go to HUNT; good_cnt <= 0.
  - The offending sample is not used to reseed HUNT.
- err_cnt:
  - Increments by 1 on each err event and saturates at 2^ERR_W-1.
  - err_clr=1 sets err_cnt to 0. This takes priority over a simultaneous increment, so the result is 0.
- A gap in en does not count as an error. Checking continues from the held exp at the next enabled sample.
- locked rises on the edge after the LOCK_CNT-th correct sample. It falls on the edge after the offending sample, in the same cycle that err pulses.

Test Plan:
- Lock acquisition: rst for 2 cycles, then en=1 with q_in = 1000, 0100, 0010, 0001 -> phase = 0,1,2,3 each with phase_vld=1; locked=1 in the cycle after 0001; err stays 0.
- Wrap and hold: after lock, continue 1000, 0100 with en=0 for 3 cycles between them -> locked stays 1; phase holds at 0 during the gap; no err; phase=1 after 0100.
- Locked error: after lock, expect 0010 but drive 1000 -> err=1 for exactly one cycle; locked=0 in the same cycle; err_cnt=1; state HUNT. Then 0100, 0010, 0001, 1000 -> relocks after the 4th.
- Illegal patterns: drive 0000 and 0110 while locked -> one err per sample, err_cnt=2, phase unchanged, phase_vld=0. Drive 1100 in HUNT -> no err.
- Saturation and clear: with ERR_W=2, force 5 locked errors -> err_cnt stops at 3. Assert err_clr in the same cycle as an err event -> err_cnt=0.
- TRACK restart and reset: drive 1000, 0100, 0001 -> no lock, no err, good_cnt restarts at 1; continue 1000, 0100, 0010 -> locked. Assert rst mid-stream -> all outputs 0 on the next cycle.
